// File: rtl/flopenr_bank_arbiter.sv
// Write controller for a bank of enable/reset flops sharing one data bus:
// round-robin write arbitration plus a one-register-per-cycle clear sweep.
module flopenr_bank_arbiter #(
    parameter  int NREQ = 4,
    parameter  int NREG = 8,
    parameter  int W    = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*W-1:0] wdata_i,
    input  logic              clr_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREG-1:0]   reg_en_o,
    output logic [W-1:0]      reg_d_o,
    output logic              wr_err_o,
    output logic              clr_busy_o,
    output logic              clr_done_o
);
    localparam int RW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   last_q, last_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREG-1:0] en_q, en_d;
    logic [W-1:0]    d_q, d_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [RW-1:0]   win;
    logic [AW-1:0]   win_addr;
    logic [AW-1:0]   cnt_nxt;
    logic            found;
    int              idx;

    // First asserted request strictly after the last winner, wrapping mod NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int o = 1; o <= NREQ; o++) begin
            idx = (int'(last_q) + o) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = RW'(idx);
            end
        end
    end

    assign win_addr = addr_i[int'(win)*AW +: AW];
    assign cnt_nxt  = cnt_q + AW'(1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        gnt_d   = '0;
        en_d    = '0;
        d_d     = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_i || pend_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    en_d    = NREG'(1);
                    busy_d  = 1'b1;
                end else if (|req_i) begin
                    state_d    = WRITE;
                    gnt_d[win] = 1'b1;
                    d_d        = wdata_i[int'(win)*W +: W];
                    last_d     = win;
                    if (int'(win_addr) < NREG) en_d  = NREG'(1) << win_addr;
                    else                       err_d = 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (clr_i) pend_d = 1'b1;
            end
            CLEAR: begin
                // cnt_q names the register being cleared in the current cycle
                if (int'(cnt_q) == NREG-1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_nxt;
                    en_d   = NREG'(1) << cnt_nxt;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= RW'(NREQ-1);
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            gnt_q   <= '0;
            en_q    <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            d_q     <= d_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign reg_en_o   = en_q;
    assign reg_d_o    = d_q;
    assign wr_err_o   = err_q;
    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;
endmodule

// File: tb/tb_flopenr_bank_arbiter.sv
// Scoreboard bench: an 8-register bank for arbitration/clear, a 6-register
// bank for the out-of-range address case.
module tb_flopenr_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req8, req6;
    logic [11:0] addr8, addr6;
    logic [31:0] wdata8, wdata6;
    logic        clr8, clr6;
    logic [3:0]  gnt8, gnt6;
    logic [7:0]  en8;
    logic [5:0]  en6;
    logic [7:0]  d8, d6;
    logic        err8, err6, busy8, busy6, done8, done6;
    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [7:0] en;
        logic [7:0] d;
        logic       err;
        logic       busy;
        logic       done;
    } rsp_t;

    rsp_t q8[$];
    rsp_t q6[$];
    rsp_t act8, exp8, act6, exp6;

    flopenr_bank_arbiter #(.NREQ(4), .NREG(8), .W(8)) u_dut8 (
        .clk(clk), .rst(rst), .req_i(req8), .addr_i(addr8), .wdata_i(wdata8),
        .clr_i(clr8), .gnt_o(gnt8), .reg_en_o(en8), .reg_d_o(d8),
        .wr_err_o(err8), .clr_busy_o(busy8), .clr_done_o(done8)
    );

    flopenr_bank_arbiter #(.NREQ(4), .NREG(6), .W(8)) u_dut6 (
        .clk(clk), .rst(rst), .req_i(req6), .addr_i(addr6), .wdata_i(wdata6),
        .clr_i(clr6), .gnt_o(gnt6), .reg_en_o(en6), .reg_d_o(d6),
        .wr_err_o(err6), .clr_busy_o(busy6), .clr_done_o(done6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int c, input logic [3:0] g, input logic [7:0] e,
                         input logic [7:0] d, input logic er, input logic bz, input logic dn);
        rsp_t r;
        r = '{c, g, e, d, er, bz, dn};
        q8.push_back(r);
    endtask

    task automatic push6(input int c, input logic [3:0] g, input logic [7:0] e,
                         input logic [7:0] d, input logic er);
        rsp_t r;
        r = '{c, g, e, d, er, 1'b0, 1'b0};
        q6.push_back(r);
    endtask

    // Busy cycles c0..c0+7 walking the one-hot enable, then one done pulse.
    task automatic push_sweep(input int c0);
        for (int i = 0; i < 8; i++) push8(c0 + i, 4'b0, 8'(1 << i), 8'h00, 1'b0, 1'b1, 1'b0);
        push8(c0 + 8, 4'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cmp(input string nm, input rsp_t a, input rsp_t e);
        nvec++;
        if (a.cyc != e.cyc || a.gnt !== e.gnt || a.en !== e.en || a.d !== e.d ||
            a.err !== e.err || a.busy !== e.busy || a.done !== e.done) begin
            nfail++;
            $display("FAIL %s: got cyc=%0d gnt=%b en=%b d=%h err=%b busy=%b done=%b, want cyc=%0d gnt=%b en=%b d=%h err=%b busy=%b done=%b",
                     nm, a.cyc, a.gnt, a.en, a.d, a.err, a.busy, a.done,
                     e.cyc, e.gnt, e.en, e.d, e.err, e.busy, e.done);
        end
    endtask

    task automatic chk_zero(input string nm);
        nvec++;
        if ({gnt8, en8, d8, err8, busy8, done8, gnt6, en6, d6, err6, busy6, done6} !== '0) begin
            nfail++;
            $display("FAIL %s: outputs gnt8=%b en8=%b d8=%h err8=%b busy8=%b done8=%b gnt6=%b en6=%b, want all zero",
                     nm, gnt8, en8, d8, err8, busy8, done8, gnt6, en6);
        end
    endtask

    always @(negedge clk) begin
        act8 = '{cyc, gnt8, en8, d8, err8, busy8, done8};
        if (|gnt8 || |en8 || |d8 || err8 || busy8 || done8) begin
            if (q8.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL dut8_unexpected: got cyc=%0d gnt=%b en=%b d=%h err=%b busy=%b done=%b, want idle outputs",
                         cyc, gnt8, en8, d8, err8, busy8, done8);
            end else begin
                exp8 = q8.pop_front();
                cmp("dut8", act8, exp8);
            end
        end
    end

    always @(negedge clk) begin
        act6 = '{cyc, gnt6, {2'b00, en6}, d6, err6, busy6, done6};
        if (|gnt6 || |en6 || |d6 || err6 || busy6 || done6) begin
            if (q6.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL dut6_unexpected: got cyc=%0d gnt=%b en=%b d=%h err=%b, want idle outputs",
                         cyc, gnt6, en6, d6, err6);
            end else begin
                exp6 = q6.pop_front();
                cmp("dut6", act6, exp6);
            end
        end
    end

    initial begin
        int c;
        logic [3:0] rr_g [3];
        logic [7:0] rr_e [3];
        logic [7:0] rr_d [3];
        rr_g = '{4'b0001, 4'b0010, 4'b1000};
        rr_e = '{8'h02, 8'h04, 8'h10};
        rr_d = '{8'h11, 8'h22, 8'h44};

        // requester slices: addr 1,2,5,4 / data 11,22,A5,44
        addr8  = {3'd4, 3'd5, 3'd2, 3'd1};
        wdata8 = {8'h44, 8'hA5, 8'h22, 8'h11};
        addr6  = {3'd0, 3'd0, 3'd5, 3'd7};
        wdata6 = {8'h00, 8'h00, 8'h66, 8'h5A};
        rst = 1'b0; req8 = 4'hF; clr8 = 1'b1; req6 = 4'h0; clr6 = 1'b0;

        // reset with everything requesting, first grant to requester 0
        tick(); tick();
        chk_zero("reset_state");
        rst = 1'b1; clr8 = 1'b0;
        push8(cyc + 1, 4'b0001, 8'h02, 8'h11, 1'b0, 1'b0, 1'b0);
        tick(); req8 = 4'h0; repeat (3) tick();

        // single write
        req8 = 4'b0100;
        push8(cyc + 1, 4'b0100, 8'h20, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick(); req8 = 4'h0; repeat (3) tick();

        // round robin 0,1,3 repeating, one grant every other cycle
        rst = 1'b0; req8 = 4'b1011; tick(); rst = 1'b1;
        c = cyc;
        for (int k = 0; k < 6; k++)
            push8(c + 1 + 2*k, rr_g[k%3], rr_e[k%3], rr_d[k%3], 1'b0, 1'b0, 1'b0);
        repeat (11) tick();
        req8 = 4'h0; repeat (2) tick();

        // clear sweep; clr during sweep ignored, req[1] waits for clr_done
        c = cyc; clr8 = 1'b1;
        push_sweep(c + 1);
        push8(c + 10, 4'b0010, 8'h04, 8'h22, 1'b0, 1'b0, 1'b0);
        tick(); clr8 = 1'b0;
        tick(); tick(); clr8 = 1'b1;
        tick(); clr8 = 1'b0; req8 = 4'b0010;
        repeat (6) tick(); req8 = 4'h0; repeat (2) tick();

        // clr during WRITE goes pending, sweep follows
        c = cyc; req8 = 4'b1000;
        push8(c + 1, 4'b1000, 8'h10, 8'h44, 1'b0, 1'b0, 1'b0);
        push_sweep(c + 3);
        tick(); req8 = 4'h0; clr8 = 1'b1;
        tick(); clr8 = 1'b0;
        repeat (11) tick();

        // clr with req in IDLE: clear first, then requester 0
        c = cyc; clr8 = 1'b1; req8 = 4'b0001;
        push_sweep(c + 1);
        push8(c + 10, 4'b0001, 8'h02, 8'h11, 1'b0, 1'b0, 1'b0);
        tick(); clr8 = 1'b0;
        repeat (9) tick(); req8 = 4'h0; repeat (2) tick();

        // 6-register bank: addr 7 dropped with wr_err, addr 5 accepted
        req6 = 4'b0001;
        push6(cyc + 1, 4'b0001, 8'h00, 8'h5A, 1'b1);
        tick(); req6 = 4'h0; repeat (2) tick();
        req6 = 4'b0010;
        push6(cyc + 1, 4'b0010, 8'h20, 8'h66, 1'b0);
        tick(); req6 = 4'h0; repeat (2) tick();

        // reset during sweep cycle 3 aborts with no clr_done
        c = cyc; clr8 = 1'b1;
        for (int i = 0; i < 3; i++) push8(c + 1 + i, 4'b0, 8'(1 << i), 8'h00, 1'b0, 1'b1, 1'b0);
        tick(); clr8 = 1'b0;
        repeat (2) tick();
        rst = 1'b0; tick();
        chk_zero("reset_mid_sweep");
        rst = 1'b1; repeat (12) tick();

        nvec++;
        if (q8.size() != 0) begin
            nfail++;
            $display("FAIL dut8_missing: got %0d responses outstanding, want 0", q8.size());
        end
        nvec++;
        if (q6.size() != 0) begin
            nfail++;
            $display("FAIL dut6_missing: got %0d responses outstanding, want 0", q6.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/flopenr_bank_arbiter.md
Name: flopenr_bank_arbiter

Overview:
- Write controller for a bank of NREG enable/reset flip-flop registers (W bits each) that share one data bus.
- Arbitrates NREQ write requesters with round-robin priority and drives exactly one one-hot register enable per write.
- Also sequences a bank-clear sweep that writes zero into every register, one per cycle.
- Sits between requesting datapath blocks and the register bank; all outputs are registered.

Parameters:
NREQ, 4, number of write requesters (>=2)
NREG, 8, number of registers in the bank (>=2, need not be a power of two)
W, 8, register data width
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, synchronous, active-low
req  in  NREQ  write request per requester; level, held until granted
addr  in  NREQ*AW  target register per requester, slice i = addr[i*AW +: AW]
wdata  in  NREQ*W  write data per requester, slice i = wdata[i*W +: W]
clr  in  1  bank-clear request, single-cycle pulse
gnt  out  NREQ  one-hot grant, 1-cycle pulse
reg_en  out  NREG  one-hot enable to the bank registers
reg_d  out  W  shared data bus to the bank
wr_err  out  1  1-cycle pulse: granted address >= NREG, write dropped
clr_busy  out  1  high throughout the clear sweep
clr_done  out  1  1-cycle pulse after the last register is cleared

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE.
  - gnt, reg_en, reg_d, wr_err, clr_busy, clr_done all 0.
  - clr_pend=0, sweep counter=0.
  - RR pointer set so requester 0 has highest priority on the first arbitration.
  - Reset overrides everything, including an in-progress sweep or write.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE, evaluated each edge, in priority order:
  - (clr | clr_pend) -> CLEAR, sweep counter=0, clr_pend cleared.
  - Else if any req -> WRITE, granting winner k:
    - k is the first asserted req at or after last_granted+1, mod NREQ.
    - At that edge, register gnt[k]=1, reg_d=wdata slice k.
    - If addr_k < NREG: reg_en[addr_k]=1. Else reg_en=0 and wr_err=1.
    - last_granted := k.
  - Else stay IDLE with all pulse outputs 0.
- WRITE: lasts exactly one cycle, then always returns to IDLE.
  - Outputs are cleared at the exit edge.
  - req is not sampled during WRITE, so a requester that drops req on seeing gnt cannot be double-granted.
  - A requester holding req high after gnt is treated as a new request at the next IDLE evaluation.
- Throughput and latency:
  - Maximum one write per 2 cycles.
  - Latency from req sampled in IDLE to gnt/reg_en: 1 cycle.
  - Bank captures the data on the edge ending the WRITE cycle.
- CLEAR:
  - Each cycle reg_en = one-hot(counter), reg_d=0, clr_busy=1; counter increments.
  - Lasts NREG cycles.
  - When the counter reaches NREG-1, next state is IDLE with clr_done=1 for one cycle and clr_busy=0.
  - req ignored during CLEAR; requests wait.
  - clr pulses received during CLEAR are ignored.
- clr arriving in WRITE, or in IDLE together with req:
  - In WRITE: clr_pend is set and serviced at the next IDLE.
  - In IDLE with req: clr wins, and req waits.
- RR pointer changes only on a grant; it is unaffected by CLEAR.
- Invariants:
  - gnt has at most one bit set.
  - reg_en has at most one bit set.
  - reg_en is never nonzero when both gnt=0 and clr_busy=0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 and clr=1 -> all outputs 0; first grant after release goes to requester 0.
- Single write: req[2]=1, addr2=5, wdata2=8'hA5 -> next cycle gnt=4'b0100, reg_en=8'b0010_0000, reg_d=8'hA5 for exactly 1 cycle; idle in between.
- Round-robin: req=4'b1011 held continuously from reset -> grants 0,1,3,0,1,3 on every other cycle; no requester is granted twice in a row while others wait.
- Clear sweep: clr pulse in IDLE -> clr_busy high 8 cycles, reg_en walks 8'h01..8'h80, reg_d=0, then clr_done pulses once; req[1] asserted mid-sweep is granted only after clr_done.
- Collision and pending:
  - clr pulsed during a WRITE cycle -> WRITE completes, then CLEAR starts on the following cycle.
  - clr together with req in IDLE -> CLEAR first.
- Error and reset mid-operation:
  - NREG=6, addr=7 granted -> gnt pulses, wr_err=1, reg_en=0.
  - rst=0 during sweep cycle 3 -> next cycle clr_busy=0, reg_en=0; no clr_done.
